// File: rtl/jtag_master_pkg.sv
// Shared types and constants for the JTAG scan master: op codes, FSM states,
// TAP instruction encodings and the scan-step helper.
package jtag_master_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_IR = 2'd1,
        OP_SHIFT_DR = 2'd2,
        OP_RUN_IDLE = 2'd3
    } jtag_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RSP  = 2'd2
    } jtag_state_e;

    localparam logic [3:0]  INSTR_BYPASS       = 4'h0;
    localparam logic [3:0]  INSTR_IDCODE       = 4'h1;
    localparam logic [3:0]  INSTR_TCP_CTRL     = 4'h8;
    localparam logic [3:0]  INSTR_TCP_STATUS   = 4'h9;
    localparam logic [3:0]  INSTR_IJTAG_ACCESS = 4'hA;
    localparam logic [31:0] IDCODE_VALUE       = 32'h1CAFE0BF;

    // TCK edges spent walking from Run-Test-Idle into the shift state.
    function automatic logic [CNT_W-1:0] preamble_len(input jtag_op_e op);
        case (op)
            OP_SHIFT_IR: return CNT_W'(4);
            OP_SHIFT_DR: return CNT_W'(3);
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: TCK_HALF clk low then TCK_HALF clk high, parked low while en=0.
// Strobes mark the clk edge on which TCK is driven low / high.
module jtag_tck_gen
    import jtag_master_pkg::*;
#(
    parameter int unsigned TCK_HALF = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int unsigned PERIOD = 2 * TCK_HALF;
    localparam int unsigned PH_W   = $clog2(PERIOD);

    logic [PH_W-1:0] phase_q;

    assign fall_stb = en && (phase_q == '0);
    assign rise_stb = en && (phase_q == PH_W'(TCK_HALF));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase_q <= '0;
            tck     <= 1'b0;
        end else begin
            phase_q <= (phase_q == PH_W'(PERIOD - 1)) ? '0 : phase_q + PH_W'(1);
            if (rise_stb) begin
                tck <= 1'b1;
            end else if (fall_stb) begin
                tck <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan sequencer: turns RESET/SHIFT_IR/SHIFT_DR/RUN_IDLE commands
// into TMS/TDI waveforms and returns captured TDO. Optional TRST_n via JTAG_MASTER_TRST_EN.
module jtag_scan_master
    import jtag_master_pkg::*;
#(
    parameter int unsigned TCK_HALF = 5,
    parameter int unsigned IR_LEN   = 4,
    parameter int unsigned DR_MAX   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [5:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
`ifdef JTAG_MASTER_TRST_EN
    ,
    output logic              TRST_n
`endif
);

    localparam int unsigned IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

    jtag_state_e       state_q, state_d;
    jtag_op_e          op_q, op_d, cmd_op_e;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
    logic [DR_MAX-1:0] data_q, data_d;
    logic [DR_MAX-1:0] cap_q, cap_d;
    logic [DR_MAX-1:0] rsp_data_d;
    logic              fin_q, fin_d;
    logic              synced_q, synced_d;
    logic              tms_d, tdi_d, busy_d, cmd_ready_d, rsp_valid_d, rsp_err_d;
    logic              gen_en, fall_stb, rise_stb;
    logic              reject_c, trst_busy;

    logic [CNT_W-1:0]  pre, total;
    logic              step_tms, step_shift;
    logic [IDX_W-1:0]  step_idx;

`ifdef JTAG_MASTER_TRST_EN
    localparam int unsigned TRST_CYC = 4 * TCK_HALF;
    localparam int unsigned TRST_W   = $clog2(TRST_CYC + 1);

    logic [TRST_W-1:0] trst_cnt_q, trst_cnt_d;
    logic              trst_n_d;

    assign trst_busy = (trst_cnt_q != '0);
`else
    assign trst_busy = 1'b0;
`endif

    assign cmd_op_e = jtag_op_e'(cmd_op);
    assign gen_en   = (state_q == S_RUN) && !fin_q && !trst_busy;

    jtag_tck_gen #(
        .TCK_HALF (TCK_HALF)
    ) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (gen_en),
        .tck      (TCK),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // Command legality check, evaluated against the offered command.
    always_comb begin
        reject_c = 1'b0;
        if (cmd_op_e != OP_RESET && !synced_q) begin
            reject_c = 1'b1;
        end
        if (cmd_op_e == OP_SHIFT_DR &&
            (cmd_len == '0 || CNT_W'(cmd_len) > CNT_W'(DR_MAX))) begin
            reject_c = 1'b1;
        end
        if (cmd_op_e == OP_RUN_IDLE && cmd_len == '0) begin
            reject_c = 1'b1;
        end
    end

    // TMS/TDI decode for the next TCK rise (index rise_cnt_q).
    always_comb begin
        pre        = preamble_len(op_q);
        total      = '0;
        step_tms   = 1'b0;
        step_shift = 1'b0;
        step_idx   = IDX_W'(rise_cnt_q - pre);
        case (op_q)
            OP_RESET: begin
                total    = CNT_W'(6);
                step_tms = (rise_cnt_q < CNT_W'(5));
            end
            OP_RUN_IDLE: begin
                total = len_q;
            end
            default: begin
                total      = pre + len_q + CNT_W'(2);
                step_shift = (rise_cnt_q >= pre) && (rise_cnt_q < pre + len_q);
                if (rise_cnt_q < pre) begin
                    step_tms = (rise_cnt_q < pre - CNT_W'(2));
                end else if (step_shift) begin
                    step_tms = (rise_cnt_q == pre + len_q - CNT_W'(1));
                end else begin
                    step_tms = (rise_cnt_q == pre + len_q);
                end
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rise_cnt_d  = rise_cnt_q;
        fin_d       = fin_q;
        synced_d    = synced_q;
        tms_d       = TMS;
        tdi_d       = TDI;
        busy_d      = busy;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
`ifdef JTAG_MASTER_TRST_EN
        trst_cnt_d  = trst_cnt_q;
        trst_n_d    = TRST_n;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (reject_c) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = S_RUN;
                        op_d       = cmd_op_e;
                        len_d      = (cmd_op_e == OP_SHIFT_IR) ? CNT_W'(IR_LEN) : CNT_W'(cmd_len);
                        data_d     = cmd_data;
                        cap_d      = '0;
                        rise_cnt_d = '0;
                        fin_d      = 1'b0;
                        busy_d     = 1'b1;
`ifdef JTAG_MASTER_TRST_EN
                        if (cmd_op_e == OP_RESET) begin
                            trst_n_d   = 1'b0;
                            trst_cnt_d = TRST_W'(TRST_CYC);
                        end
`endif
                    end
                end
            end
            S_RUN: begin
                if (fin_q) begin
                    state_d     = S_RSP;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = cap_q;
                    if (op_q == OP_RESET) begin
                        synced_d = 1'b1;
                    end
                end else begin
`ifdef JTAG_MASTER_TRST_EN
                    if (trst_busy) begin
                        trst_cnt_d = trst_cnt_q - TRST_W'(1);
                        if (trst_cnt_q == TRST_W'(1)) begin
                            trst_n_d = 1'b1;
                        end
                    end
`endif
                    // The fall after the last rise ends the scan; TCK stays parked low.
                    if (fall_stb) begin
                        if (rise_cnt_q == total) begin
                            fin_d = 1'b1;
                            tdi_d = 1'b0;
                        end else begin
                            tms_d = step_tms;
                            tdi_d = step_shift ? data_q[step_idx] : 1'b0;
                        end
                    end
                    if (rise_stb) begin
                        rise_cnt_d = rise_cnt_q + CNT_W'(1);
                        if (step_shift) begin
                            cap_d[step_idx] = TDO;
                        end
                    end
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_RESET;
            len_q      <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            rise_cnt_q <= '0;
            fin_q      <= 1'b0;
            synced_q   <= 1'b0;
            TMS        <= 1'b1;
            TDI        <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
            trst_cnt_q <= '0;
            TRST_n     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            rise_cnt_q <= rise_cnt_d;
            fin_q      <= fin_d;
            synced_q   <= synced_d;
            TMS        <= tms_d;
            TDI        <= tdi_d;
            busy       <= busy_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_err    <= rsp_err_d;
`ifdef JTAG_MASTER_TRST_EN
            trst_cnt_q <= trst_cnt_d;
            TRST_n     <= trst_n_d;
`endif
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master driving a behavioural 1149.1 TAP with
// IDCODE, TCP_CTRL (read/write), TCP_STATUS and BYPASS data registers.
module tb_jtag_scan_master;
    import jtag_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        TCK, TMS, TDI, TDO;
`ifdef JTAG_MASTER_TRST_EN
    logic        TRST_n;
`endif

    int n_vec = 0;
    int n_err = 0;
    int rises = 0;

    always #5 clk = ~clk;

    jtag_scan_master #(
        .TCK_HALF (5),
        .IR_LEN   (4),
        .DR_MAX   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO)
`ifdef JTAG_MASTER_TRST_EN
        ,
        .TRST_n    (TRST_n)
`endif
    );

    // Behavioural TAP controller.
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e        tap   = TLR;
    logic [3:0]  ir    = INSTR_IDCODE;
    logic [3:0]  ir_sr = 4'h0;
    logic [31:0] dr_sr = 32'h0;
    logic [31:0] ctrl  = 32'h0;
    logic        bp    = 1'b0;
    logic        tdo   = 1'b0;
    logic        is_bypass;

    assign TDO       = tdo;
    assign is_bypass = !(ir == INSTR_IDCODE || ir == INSTR_TCP_CTRL || ir == INSTR_TCP_STATUS);

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PA_DR;
            PA_DR:   return m ? EX2_DR : PA_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PA_IR;
            PA_IR:   return m ? EX2_IR : PA_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        rises = rises + 1;
        case (tap)
            TLR:    ir <= INSTR_IDCODE;
            CAP_IR: ir_sr <= 4'b0001;
            SH_IR:  ir_sr <= {TDI, ir_sr[3:1]};
            UPD_IR: ir <= ir_sr;
            CAP_DR: begin
                bp <= 1'b0;
                case (ir)
                    INSTR_IDCODE:     dr_sr <= 32'h1CAFE0BF;
                    INSTR_TCP_CTRL:   dr_sr <= ctrl;
                    INSTR_TCP_STATUS: dr_sr <= 32'hDEADBEEF;
                    default:          dr_sr <= 32'h0;
                endcase
            end
            SH_DR: begin
                bp    <= TDI;
                dr_sr <= {TDI, dr_sr[31:1]};
            end
            UPD_DR: if (ir == INSTR_TCP_CTRL) ctrl <= dr_sr;
            default: ;
        endcase
        tap <= tap_next(tap, TMS);
    end

    always @(negedge TCK) begin
        if (tap == SH_DR)      tdo <= is_bypass ? bp : dr_sr[0];
        else if (tap == SH_IR) tdo <= ir_sr[0];
        else                   tdo <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one command, wait (bounded) for its response; cycles counted from the accept edge.
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           output logic vld, output logic [31:0] d, output logic e,
                           output int nr, output int lat, output int cyc);
        int t;
        @(negedge clk);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        rises = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        cyc = 0;
        while (!rsp_valid && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (TCK && lat == 0) lat = cyc;
        end
        vld = rsp_valid;
        d   = rsp_data;
        e   = rsp_err;
        nr  = rises;
    endtask

    task automatic ack();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic        rv, re;
        logic [31:0] rd;
        int          rn, rl, rc, t;

        repeat (3) @(negedge clk);
        check("rst_tck",       32'(TCK),       32'd0);
        check("rst_tms",       32'(TMS),       32'd1);
        check("rst_tdi",       32'(TDI),       32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;

        // Unsynced master rejects everything but RESET
        run_cmd(2'd2, 6'd8, 32'hFF, rv, rd, re, rn, rl, rc);
        check("nosync_vld",   32'(rv),   32'd1);
        check("nosync_err",   32'(re),   32'd1);
        check("nosync_data",  rd,        32'd0);
        check("nosync_tck",   32'(rn),   32'd0);
        check("nosync_lat",   32'(rc),   32'd0);
        check("nosync_busy",  32'(busy), 32'd0);
        ack();

        run_cmd(2'd0, 6'd0, 32'h0, rv, rd, re, rn, rl, rc);
        check("reset_vld",  32'(rv), 32'd1);
        check("reset_err",  32'(re), 32'd0);
        check("reset_data", rd,      32'd0);
        check("reset_tck",  32'(rn), 32'd6);
        check("reset_cyc",  32'(rc), 32'd62);
        ack();

        run_cmd(2'd2, 6'd32, 32'h0, rv, rd, re, rn, rl, rc);
        check("idcode_vld",  32'(rv), 32'd1);
        check("idcode_data", rd,      32'h1CAFE0BF);
        check("idcode_err",  32'(re), 32'd0);
        check("idcode_tck",  32'(rn), 32'd37);
        check("idcode_lat",  32'(rl), 32'd6);
        check("idcode_cyc",  32'(rc), 32'd372);
        ack();

        run_cmd(2'd1, 6'd0, 32'h8, rv, rd, re, rn, rl, rc);
        check("ir_ctrl_cap", rd,      32'h1);
        check("ir_ctrl_tck", 32'(rn), 32'd10);
        check("ir_ctrl_cyc", 32'(rc), 32'd102);
        ack();
        run_cmd(2'd2, 6'd32, 32'hA5A55A5A, rv, rd, re, rn, rl, rc);
        check("ctrl_wr_data", rd,      32'h0);
        check("ctrl_wr_tck",  32'(rn), 32'd37);
        ack();
        run_cmd(2'd2, 6'd32, 32'h0, rv, rd, re, rn, rl, rc);
        check("ctrl_rd_data", rd, 32'hA5A55A5A);
        ack();

        run_cmd(2'd1, 6'd0, 32'h9, rv, rd, re, rn, rl, rc);
        ack();
        run_cmd(2'd2, 6'd32, 32'h0, rv, rd, re, rn, rl, rc);
        check("status_data", rd,      32'hDEADBEEF);
        check("status_err",  32'(re), 32'd0);
        ack();

        // Bypass: one-bit delay, response held while rsp_ready stays low
        run_cmd(2'd1, 6'd0, 32'h0, rv, rd, re, rn, rl, rc);
        ack();
        run_cmd(2'd2, 6'd2, 32'h3, rv, rd, re, rn, rl, rc);
        check("bypass_data", rd,      32'h2);
        check("bypass_tck",  32'(rn), 32'd7);
        repeat (20) @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        ack();
        check("retire_rsp_valid", 32'(rsp_valid), 32'd0);
        check("retire_cmd_ready", 32'(cmd_ready), 32'd1);

        run_cmd(2'd3, 6'd7, 32'h0, rv, rd, re, rn, rl, rc);
        check("idle7_err", 32'(re), 32'd0);
        check("idle7_tck", 32'(rn), 32'd7);
        check("idle7_cyc", 32'(rc), 32'd72);
        ack();
        run_cmd(2'd3, 6'd0, 32'h0, rv, rd, re, rn, rl, rc);
        check("idle0_err", 32'(re), 32'd1);
        check("idle0_tck", 32'(rn), 32'd0);
        ack();
        run_cmd(2'd2, 6'd33, 32'h0, rv, rd, re, rn, rl, rc);
        check("dr33_err", 32'(re), 32'd1);
        check("dr33_tck", 32'(rn), 32'd0);
        ack();
        run_cmd(2'd2, 6'd0, 32'h0, rv, rd, re, rn, rl, rc);
        check("dr0_err", 32'(re), 32'd1);
        ack();

        // Reset in the middle of a DR scan
        @(negedge clk);
        cmd_op    = 2'd2;
        cmd_len   = 6'd32;
        cmd_data  = 32'h0;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        rises = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (rises < 10 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("abort_rises", 32'(rises), 32'd10);
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tck",       32'(TCK),       32'd0);
        check("abort_tms",       32'(TMS),       32'd1);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;

        run_cmd(2'd1, 6'd0, 32'h8, rv, rd, re, rn, rl, rc);
        check("post_abort_vld",  32'(rv), 32'd1);
        check("post_abort_err",  32'(re), 32'd1);
        check("post_abort_tck",  32'(rn), 32'd0);
        check("post_abort_data", rd,      32'd0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

Host-side JTAG scan sequencer that drives the on-chip `tap_controller` pins (TCK/TMS/TDI, sampling TDO) from a simple command/response interface. It sits between a system-clock bus agent (debug bridge or test sequencer) and the TAP. It converts RESET / SHIFT_IR / SHIFT_DR / RUN_IDLE commands into IEEE 1149.1-compliant TMS/TDI waveforms at a programmable TCK rate, and returns captured TDO bits.

## Interface
Parameters:
- `TCK_HALF` = 5 — clk cycles per TCK half-period; ≥2. At 100 MHz clk this gives 10 MHz TCK, the maximum allowed.
- `IR_LEN` = 4 — instruction register length; must match the TAP.
- `DR_MAX` = 32 — maximum DR scan length and data width.

Ports:
- `clk` in 1 — system clock; the only clock.
- `rst` in 1 — synchronous, active-high reset.
- `cmd_valid` in 1 — command offered.
- `cmd_ready` out 1 — command accepted when both valid and ready are high.
- `cmd_op` in 2 — 0 RESET, 1 SHIFT_IR, 2 SHIFT_DR, 3 RUN_IDLE.
- `cmd_len` in 6 — DR bit count (1..DR_MAX) or RUN_IDLE TCK count (1..63). Ignored for RESET and SHIFT_IR.
- `cmd_data` in DR_MAX — TDI bits, LSB shifted first.
- `rsp_valid` out 1 — response available; held until rsp_ready.
- `rsp_ready` in 1 — response consumed.
- `rsp_data` out DR_MAX — captured TDO, bit i = i-th shifted bit, right-aligned, upper bits zero.
- `rsp_err` out 1 — command rejected; no TCK edges were issued.
- `busy` out 1 — scan in progress.
- `TCK`, `TMS`, `TDI` out 1 — JTAG pins.
- `TDO` in 1 — JTAG return.

## Operation
- A command is accepted only in S_IDLE with no pending response. `cmd_ready` = (state==S_IDLE) && !rsp_valid.
- TMS sequence per op. RTI = Run-Test-Idle. Each listed value applies to one TCK rising edge.
  - RESET: TMS 1×5, then 0. Ends in RTI. 6 TCK. Sets internal `synced`.
  - SHIFT_IR: TMS 1,1,0,0, then IR_LEN shift edges (TMS 0, last 1), then 1 (Update-IR), 0 (RTI). IR_LEN+6 TCK.
  - SHIFT_DR: TMS 1,0,0, then cmd_len shift edges (last TMS=1), then 1, 0. cmd_len+5 TCK.
  - RUN_IDLE: cmd_len edges with TMS=0.
- TDI carries `cmd_data[i]` during shift edge i and is 0 otherwise.
- TDO is sampled on each shift edge into `rsp_data[i]`. For SHIFT_IR, rsp_data holds the IR capture value.
- Rejections (rsp_err=1, rsp_data=0, response in the next cycle, zero TCK edges):
  - any non-RESET op while `synced`=0;
  - SHIFT_DR with cmd_len=0 or cmd_len>DR_MAX;
  - RUN_IDLE with cmd_len=0.
- FSM: S_IDLE → S_RUN (walk TMS table via bit/edge counters) → S_RSP → S_IDLE once rsp_ready is seen. The RESET response carries rsp_data=0.

## Timing
- Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, synced=0.
- TCK idles low. Each TCK period is TCK_HALF clk low, then TCK_HALF clk high.
- TMS/TDI change only in the clk cycle that drives TCK low. They are therefore stable for TCK_HALF cycles before every rising edge.
- TDO is sampled on the clk edge that raises TCK. The TAP updated TDO on the previous falling edge.
- Latency: cmd accept → first TCK rise = TCK_HALF+1 clk. Last TCK fall → rsp_valid = 1 clk.
- `busy` is high from the cycle after accept until rsp_valid rises.
- Reset mid-scan aborts immediately: outputs take reset values and synced clears. The TAP state is then undefined until the next RESET command.
- rsp_valid and rsp_ready high together at the same moment as cmd_valid: the response retires this cycle, and the command is accepted next cycle.

## Configuration
- `JTAG_MASTER_TRST_EN` defined:
  - adds output `TRST_n`, reset value 1;
  - RESET op first drives TRST_n=0 for 2 full TCK periods with TCK held low, then releases it, then runs the 6-edge TMS sequence.
- Undefined: no TRST_n port; reset is via TMS only.

## Structure
- `jtag_master_pkg` contains:
  - the `jtag_op_e` enum (RESET/SHIFT_IR/SHIFT_DR/RUN_IDLE);
  - the FSM state enum;
  - the TAP instruction constants: BYPASS 4'h0, IDCODE 4'h1, TCP_CTRL 4'h8, TCP_STATUS 4'h9, IJTAG_ACCESS 4'hA;
  - the expected IDCODE value 32'h1CAFE0BF.
- Sub-module `jtag_tck_gen` contains the TCK_HALF divider. It emits one-cycle `fall_stb`/`rise_stb` strobes and the TCK pin, and has an enable that parks TCK low.

## Test plan
Bench pairs the master with a real `tap_controller`; clk = 100 MHz, TCK_HALF=5.
- SHIFT_DR len 8 before any RESET → rsp_err=1, zero TCK edges.
- RESET, then SHIFT_DR len 32 → rsp_data=32'h1CAFE0BF (IDCODE), rsp_err=0, exactly 37 TCK rises.
- SHIFT_IR 4'h8, then SHIFT_DR 32'hA5A55A5A, then SHIFT_DR 32'h0 → second response returns 32'hA5A55A5A.
- SHIFT_IR 4'h9, then SHIFT_DR len 32 → rsp_data=32'hDEADBEEF.
- SHIFT_IR 4'h0, then SHIFT_DR len 2 with data 2'b11 → rsp_data=2'b10 (1-bit bypass delay). rsp_ready held low for 20 cycles → rsp_valid stays high and cmd_ready stays 0.
- Assert rst after the 10th TCK of a SHIFT_DR → next cycle TCK=0, TMS=1, busy=0. The following SHIFT_IR is rejected with rsp_err=1.
